// File: rtl/spi_adc_sampler.sv
// spi_adc_sampler: MCP3208-style SPI front end.
// Scans NUM_CH channels per tick; publishes all at once.
module spi_adc_sampler #(
  parameter int NUM_CH        = 4,
  parameter int ADC_BITS      = 12,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic                     enable_in,
  output logic                     sclk_out,
  output logic                     cs_n_out,
  output logic                     mosi_out,
  input  logic                     miso_in,
  output logic [NUM_CH-1:0][15:0]  adc_out,
  output logic                     valid_out,
  output logic                     busy_out,
  output logic                     overrun_out
);

  localparam int NB = 18;
  localparam int FD = NB - ADC_BITS;
  localparam int CW = $clog2(2 * CLK_DIV);
  localparam int TW = $clog2(SAMPLE_PERIOD + 1);

  typedef enum logic [2:0] {
    IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE
  } state_t;

  state_t              state, state_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [4:0]          bitk, bit_d;
  logic [2:0]          ch, ch_d;
  logic [TW-1:0]       tcnt;
  logic                tick, sample, last_bit;
  logic                spi_on, cmd;
  logic                sclk_d, cs_n_d, mosi_d;
  logic [ADC_BITS-1:0] shreg, word;
  logic [ADC_BITS-1:0] shadow [NUM_CH];

  assign tick     = enable_in && (tcnt == '0);
  assign busy_out = (state != IDLE);
  assign last_bit = (bitk == 5'(NB - 1));
  assign word     = {shreg[ADC_BITS-2:0], miso_in};

  // sample-period counter, parked at zero while disabled
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= '0;
    end else if (!enable_in) begin
      tcnt <= '0;
    end else if (tcnt == TW'(SAMPLE_PERIOD - 1)) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  // frame sequencing: next state, counters, SPI pins
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bitk;
    ch_d    = ch;
    sample  = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_d = CS_SETUP;
          cnt_d   = '0;
          bit_d   = '0;
          ch_d    = '0;
        end
      end
      CS_SETUP: begin
        if (cnt == CW'(CLK_DIV - 1)) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (cnt == CW'(2 * CLK_DIV - 1)) begin
          cnt_d  = '0;
          sample = (bitk >= 5'(FD));
          if (last_bit) begin
            state_d = CS_HOLD;
          end else begin
            bit_d = bitk + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      CS_HOLD: begin
        if (cnt == CW'(2 * CLK_DIV - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          if (ch == 3'(NUM_CH - 1)) begin
            state_d = DONE;
          end else begin
            state_d = CS_SETUP;
            ch_d    = ch + 1'b1;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ch_d    = '0;
      end
      default: state_d = IDLE;
    endcase

    unique case (1'b1)
      (bit_d < 5'd2):  cmd = 1'b1;
      (bit_d == 5'd2): cmd = ch_d[2];
      (bit_d == 5'd3): cmd = ch_d[1];
      (bit_d == 5'd4): cmd = ch_d[0];
      default:         cmd = 1'b0;
    endcase

    spi_on = (state_d == CS_SETUP) || (state_d == SHIFT);
    cs_n_d = !spi_on;
    sclk_d = (state_d == SHIFT) && (cnt_d >= CW'(CLK_DIV));
    mosi_d = spi_on && cmd;
  end

  // state and counter registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      bitk  <= '0;
      ch    <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      bitk  <= bit_d;
      ch    <= ch_d;
    end
  end

  // SPI pins registered so SCLK/CS are glitch free
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_out <= 1'b1;
      sclk_out <= 1'b0;
      mosi_out <= 1'b0;
    end else begin
      cs_n_out <= cs_n_d;
      sclk_out <= sclk_d;
      mosi_out <= mosi_d;
    end
  end

  // shift in data bits on SCLK fall, park result per channel
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        shadow[i] <= '0;
      end
    end else if (sample) begin
      shreg <= word;
      if (last_bit) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch == 3'(i)) begin
            shadow[i] <= word;
          end
        end
      end
    end
  end

  // atomic publish, valid strobe, sticky overrun
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      adc_out     <= '0;
      valid_out   <= 1'b0;
      overrun_out <= 1'b0;
    end else begin
      if (state == DONE) begin
        for (int i = 0; i < NUM_CH; i++) begin
          adc_out[i] <= 16'(shadow[i]);
        end
      end
      valid_out   <= (state == DONE);
      overrun_out <= overrun_out | (tick && busy_out);
    end
  end

endmodule

// File: doc/spi_adc_sampler.md
Name: spi_adc_sampler

Overview:
Receive-side front end that reads the four receiver ADCs over SPI and delivers one 16-bit sample per channel to receive_beamform's adc_in array. It drives the ADC's serial command/readout frame (MCP3208-style, single-ended, 12-bit), scans channels 0..NUM_CH-1 once per sample tick, and publishes all channels together with a one-cycle valid strobe. It runs on the 100 MHz system clock.

Parameters:
NUM_CH, 4, channels scanned per sample set (1..8)
ADC_BITS, 12, conversion result width
CLK_DIV, 4, SCLK half-period in clk_in cycles (>=2); default gives 12.5 MHz SCLK
SAMPLE_PERIOD, 1000, clk_in cycles between scan starts (default 100 kS/s per channel)

Ports:
clk_in  input  1  system clock, 100 MHz
rst_n  input  1  asynchronous active-low reset
enable_in  input  1  high = free-running sampling; low = idle after the current scan finishes
sclk_out  output  1  SPI clock to ADC, idle low (mode 0)
cs_n_out  output  1  ADC chip select, active low
mosi_out  output  1  command bits to ADC
miso_in  input  1  ADC data out
adc_out  output  [NUM_CH][16]  latest sample set, zero-extended raw code {4'b0, code}
valid_out  output  1  one-cycle pulse when adc_out updates
busy_out  output  1  high while a scan is in progress
overrun_out  output  1  sticky; a sample tick arrived while busy

Behaviour:
- Reset (async, immediate): cs_n_out=1, sclk_out=0, mosi_out=0, adc_out all 0, valid_out=0, busy_out=0, overrun_out=0, FSM=IDLE, tick counter=0, channel index=0. Reset mid-frame aborts with CS deasserted in the same instant; no partial data reaches adc_out.
- Tick counter: held at 0 while enable_in=0; otherwise counts 0..SAMPLE_PERIOD-1 and wraps. A tick fires when count==0 and enable_in=1, so the first scan starts on the first edge with enable_in high.
- FSM: IDLE -> CS_SETUP on tick. CS_SETUP: cs_n low, sclk low, mosi = first command bit, hold CLK_DIV cycles -> SHIFT. SHIFT: 18 SCLK periods, each CLK_DIV low then CLK_DIV high -> CS_HOLD. CS_HOLD: cs_n high, 2*CLK_DIV cycles -> CS_SETUP for the next channel, or DONE after channel NUM_CH-1. DONE: one cycle; copy the shadow buffer to adc_out, pulse valid_out -> IDLE.
- Frame bit k = 0..17. mosi: k0=1 (start), k1=1 (single-ended), k2..k4=channel[2:0] MSB first, k>=5 -> 0. mosi changes only while sclk is low, at the start of each low phase. k5 is the null bit and is ignored. k6..k17 are data MSB first: miso is sampled on the clk_in edge where sclk goes high->low, which gives the ADC a full half-period to settle.
- Each channel's 12-bit result goes to a shadow register. adc_out changes only in DONE, so all channels update atomically.
- Scan length = NUM_CH*(CLK_DIV + 36*CLK_DIV + 2*CLK_DIV) + 1 cycles (625 at defaults). busy_out=1 from the first CS_SETUP cycle through DONE inclusive.
- Tick while not IDLE: the tick is dropped, overrun_out is set and stays set until reset, and the current scan continues unaffected.
- enable_in falling mid-scan: the scan completes and valid_out fires, then the FSM stays in IDLE.
- valid_out never asserts for two consecutive cycles.

Test Plan:
- ADC model returns code 0xA5C+ch: enable_in=1 -> after 625 cycles valid_out pulses once; adc_out = 0x0A5C, 0x0A5D, 0x0A5E, 0x0A5F; busy_out drops in the same cycle.
- Frame check on channel 2: mosi bits k0..k4 sampled at SCLK rising edges = 1,1,0,1,0; exactly 18 SCLK rising edges per cs_n low window; SCLK high and low each last 4 clk_in cycles; cs_n high for 8 cycles between frames.
- Free-run: scan starts are 1000 cycles apart; next set 0x0FFF,0x0000,0x0800,0x0001 -> adc_out does not change until that set's valid_out; overrun_out stays 0.
- Overrun: SAMPLE_PERIOD=500 -> overrun_out=1 at cycle 500, scan still completes with correct data, next scan starts on the tick at cycle 1000.
- Assert rst_n=0 during channel 1, bit 9 -> cs_n_out=1 and sclk_out=0 asynchronously; adc_out keeps its reset value of 0; after release, a full scan gives correct data.
- enable_in dropped at cycle 300 of a scan -> valid_out at cycle 625, then no further cs_n activity for 2000 cycles.
